// File: rtl/eth_tx_arb.sv
// Frame-granular round-robin arbiter sharing one MAC TX datapath between N_REQ requesters.
// Latency: 1 cycle from granted-requester inputs to tx_*; grant is registered (gnt_o one cycle after arbitration).
// Backpressure: none on the bus; requesters hold req_i until granted, and idle/expired grants are reclaimed.
//
// Ports:
//   clk, nreset                 clock, synchronous active-low reset
//   req_i/valid_i/start_i/term_i/cancel_i [N_REQ]  per-requester request and beat qualifiers
//   data_i [N_REQ*DATA_W], len_i [N_REQ*LEN_W]     flattened per-requester data and valid-byte count
//   gnt_o [N_REQ]               one-hot registered grant
//   tx_valid_o/tx_start_o/tx_term_o/tx_cancel_o/tx_data_o/tx_len_o  shared TX bus
//   timeout_o                   pulse when a grant is revoked for never starting a frame
module eth_tx_arb #(
    parameter int DATA_W        = 16,
    parameter int LEN_W         = $clog2(DATA_W/8 + 1),
    parameter int N_REQ         = 2,
    parameter int IFG_CYC       = 6,
    parameter int START_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ-1:0]          valid_i,
    input  logic [N_REQ-1:0]          start_i,
    input  logic [N_REQ-1:0]          term_i,
    input  logic [N_REQ-1:0]          cancel_i,
    input  logic [N_REQ*DATA_W-1:0]   data_i,
    input  logic [N_REQ*LEN_W-1:0]    len_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic                      tx_valid_o,
    output logic                      tx_start_o,
    output logic                      tx_term_o,
    output logic                      tx_cancel_o,
    output logic [DATA_W-1:0]         tx_data_o,
    output logic [LEN_W-1:0]          tx_len_o,
    output logic                      timeout_o
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int CNT_MAX = (IFG_CYC > START_TIMEOUT) ? IFG_CYC : START_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_IFG} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gid_q, gid_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tx_valid_q, tx_valid_d;
    logic                tx_start_q, tx_start_d;
    logic                tx_term_q, tx_term_d;
    logic                tx_cancel_q, tx_cancel_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [LEN_W-1:0]    tx_len_q, tx_len_d;
    logic                timeout_q, timeout_d;

    // Lane of the currently granted requester.
    logic                r_req, r_vld, r_sop, r_eop, r_can;
    logic [DATA_W-1:0]   r_dat;
    logic [LEN_W-1:0]    r_len;

    // Round-robin pick.
    logic                found;
    logic [PTR_W-1:0]    pick;
    logic [PTR_W-1:0]    idx;
    logic                end_frame;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        r_req = 1'b0;
        r_vld = 1'b0;
        r_sop = 1'b0;
        r_eop = 1'b0;
        r_can = 1'b0;
        r_dat = '0;
        r_len = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gid_q == PTR_W'(k)) begin
                r_req = req_i[k];
                r_vld = valid_i[k];
                r_sop = start_i[k];
                r_eop = term_i[k];
                r_can = cancel_i[k];
                r_dat = data_i[k*DATA_W +: DATA_W];
                r_len = len_i[k*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        tx_valid_d  = 1'b0;
        tx_start_d  = 1'b0;
        tx_term_d   = 1'b0;
        tx_cancel_d = 1'b0;
        tx_data_d   = '0;
        tx_len_d    = '0;
        timeout_d   = 1'b0;
        end_frame   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    gid_d       = pick;
                    cnt_d       = '0;
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                if (r_can) begin
                    tx_cancel_d = 1'b1;
                    end_frame   = 1'b1;
                end else if (r_vld && r_sop) begin
                    tx_valid_d = 1'b1;
                    tx_start_d = 1'b1;
                    tx_term_d  = r_eop;
                    tx_data_d  = r_dat;
                    tx_len_d   = r_eop ? r_len : '0;
                    if (r_eop) end_frame = 1'b1;
                    else       state_d   = S_XFER;
                end else if (!r_req) begin
                    // Requester withdrew before using the grant.
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ptr_d   = next_ptr(gid_q);
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    gnt_d     = '0;
                    ptr_d     = next_ptr(gid_q);
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_XFER: begin
                // A second start inside a frame is treated like a cancel.
                if (r_can || (r_vld && r_sop)) begin
                    tx_cancel_d = 1'b1;
                    end_frame   = 1'b1;
                end else if (r_vld) begin
                    tx_valid_d = 1'b1;
                    tx_term_d  = r_eop;
                    tx_data_d  = r_dat;
                    tx_len_d   = r_eop ? r_len : '0;
                    if (r_eop) end_frame = 1'b1;
                end
            end
            S_IFG: begin
                // Counts IFG_CYC..0, so the gap state lasts IFG_CYC+1 cycles and
                // the following IDLE arbitration cycle completes the minimum spacing.
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (end_frame) begin
            gnt_d = '0;
            ptr_d = next_ptr(gid_q);
            if (IFG_CYC == 0) begin
                state_d = S_IDLE;
            end else begin
                state_d = S_IFG;
                cnt_d   = CNT_W'(IFG_CYC);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gid_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_term_q   <= 1'b0;
            tx_cancel_q <= 1'b0;
            tx_data_q   <= '0;
            tx_len_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gid_q       <= gid_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_start_q  <= tx_start_d;
            tx_term_q   <= tx_term_d;
            tx_cancel_q <= tx_cancel_d;
            tx_data_q   <= tx_data_d;
            tx_len_q    <= tx_len_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_start_o  = tx_start_q;
    assign tx_term_o   = tx_term_q;
    assign tx_cancel_o = tx_cancel_q;
    assign tx_data_o   = tx_data_q;
    assign tx_len_o    = tx_len_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a frame-level reference model of the arbitration rules.
module tb_eth_tx_arb;

    localparam int DATA_W        = 16;
    localparam int LEN_W         = 2;
    localparam int N_REQ         = 2;
    localparam int IFG_CYC       = 6;
    localparam int START_TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    nreset = 1'b0;
    logic [N_REQ-1:0]        req_i = '0, valid_i = '0, start_i = '0, term_i = '0, cancel_i = '0;
    logic [N_REQ*DATA_W-1:0] data_i = '0;
    logic [N_REQ*LEN_W-1:0]  len_i = '0;
    logic [N_REQ-1:0]        gnt_o;
    logic                    tx_valid_o, tx_start_o, tx_term_o, tx_cancel_o, timeout_o;
    logic [DATA_W-1:0]       tx_data_o;
    logic [LEN_W-1:0]        tx_len_o;

    int errors = 0;
    int checks = 0;

    eth_tx_arb #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .N_REQ(N_REQ),
        .IFG_CYC(IFG_CYC), .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk(clk), .nreset(nreset),
        .req_i(req_i), .valid_i(valid_i), .start_i(start_i), .term_i(term_i),
        .cancel_i(cancel_i), .data_i(data_i), .len_i(len_i),
        .gnt_o(gnt_o), .tx_valid_o(tx_valid_o), .tx_start_o(tx_start_o),
        .tx_term_o(tx_term_o), .tx_cancel_o(tx_cancel_o), .tx_data_o(tx_data_o),
        .tx_len_o(tx_len_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: requester holding the grant (-1 none); mid: a frame has started;
    // gap: idle cycles still owed before arbitration may run again.
    int  m_owner = -1;
    bit  m_mid = 1'b0;
    int  m_gap = 0;
    int  m_wait = 0;
    int  m_rr = 0;
    logic [N_REQ-1:0]  e_gnt = '0;
    logic              e_valid = 1'b0, e_start = 1'b0, e_term = 1'b0, e_cancel = 1'b0, e_timeout = 1'b0;
    logic [DATA_W-1:0] e_data = '0;
    logic [LEN_W-1:0]  e_len = '0;

    task automatic release_grant(input int k, input bit frame_done);
        m_owner = -1;
        m_mid   = 1'b0;
        m_rr    = (k + 1) % N_REQ;
        if (frame_done) m_gap = (IFG_CYC == 0) ? 0 : IFG_CYC + 1;
    endtask

    task automatic model_step();
        int k;
        e_valid = 1'b0; e_start = 1'b0; e_term = 1'b0; e_cancel = 1'b0; e_timeout = 1'b0;
        e_data = '0; e_len = '0;
        if (!nreset) begin
            m_owner = -1; m_mid = 1'b0; m_gap = 0; m_rr = 0;
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (m_owner < 0) begin
            for (int i = 0; i < N_REQ; i++) begin
                k = (m_rr + i) % N_REQ;
                if (m_owner < 0 && req_i[k]) begin
                    m_owner = k; m_wait = 0; m_mid = 1'b0;
                end
            end
        end else begin
            k = m_owner;
            if (cancel_i[k] || (m_mid && valid_i[k] && start_i[k])) begin
                e_cancel = 1'b1;
                release_grant(k, 1'b1);
            end else if (valid_i[k] && (m_mid || start_i[k])) begin
                e_valid = 1'b1;
                e_start = start_i[k];
                e_term  = term_i[k];
                e_data  = data_i[k*DATA_W +: DATA_W];
                e_len   = term_i[k] ? len_i[k*LEN_W +: LEN_W] : '0;
                m_mid   = 1'b1;
                if (term_i[k]) release_grant(k, 1'b1);
            end else if (!m_mid) begin
                if (!req_i[k]) begin
                    release_grant(k, 1'b0);
                end else if (m_wait == START_TIMEOUT - 1) begin
                    e_timeout = 1'b1;
                    release_grant(k, 1'b0);
                end else begin
                    m_wait++;
                end
            end
        end
        e_gnt = (m_owner >= 0) ? (N_REQ'(1) << m_owner) : '0;
    endtask

    // Compare process: checks the outputs of the last edge, then advances the model
    // with the inputs that the next edge will sample.
    initial forever begin
        @(negedge clk);
        chk("gnt", gnt_o, e_gnt);
        chk("tx_valid", tx_valid_o, e_valid);
        chk("tx_start", tx_start_o, e_start);
        chk("tx_term", tx_term_o, e_term);
        chk("tx_cancel", tx_cancel_o, e_cancel);
        chk("tx_data", tx_data_o, e_data);
        chk("tx_len", tx_len_o, e_len);
        chk("timeout", timeout_o, e_timeout);
        model_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lane(input int k, input logic v, input logic s, input logic t, input logic c,
                        input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
        valid_i[k]  = v;
        start_i[k]  = s;
        term_i[k]   = t;
        cancel_i[k] = c;
        data_i[k*DATA_W +: DATA_W] = d;
        len_i[k*LEN_W +: LEN_W]    = l;
    endtask

    task automatic junk(input int k);
        lane(k, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), DATA_W'($urandom), LEN_W'($urandom));
    endtask

    task automatic idle_lanes();
        valid_i = '0; start_i = '0; term_i = '0; cancel_i = '0; data_i = '0; len_i = '0;
    endtask

    task automatic do_reset();
        idle_lanes();
        req_i  = '0;
        nreset = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
    endtask

    task automatic wait_gnt(input int max_cyc);
        for (int i = 0; i < max_cyc && gnt_o == '0; i++) tick();
    endtask

    initial begin
        logic [N_REQ-1:0] g_seq[$];
        logic [N_REQ-1:0] exp_seq[4];
        logic [N_REQ-1:0] prev_gnt;
        int bidx[N_REQ];
        int last_term, cyc_i, nhi;
        int pv[3], ps[3], pt[3], pc[3];

        // Reset then idle.
        do_reset();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_valid", tx_valid_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_gnt", gnt_o, 0);
            chk("idle_valid", tx_valid_o, 0);
        end

        // Single requester, 4-beat frame, term len=1.
        req_i = 2'b01;
        tick();
        chk("single_gnt", gnt_o, 2'b01);
        req_i = '0;
        for (int b = 0; b < 4; b++) begin
            lane(0, 1'b1, 1'(b == 0), 1'(b == 3), 1'b0, 16'hA000 + 16'(b), (b == 3) ? 2'd1 : 2'd0);
            tick();
            chk("single_valid", tx_valid_o, 1);
            chk("single_data", tx_data_o, 16'hA000 + 16'(b));
            chk("single_start", tx_start_o, (b == 0) ? 1 : 0);
            chk("single_term", tx_term_o, (b == 3) ? 1 : 0);
        end
        chk("single_len", tx_len_o, 1);
        idle_lanes();
        for (int i = 0; i < 6; i++) begin
            chk("single_ifg_gnt", gnt_o, 0);
            tick();
        end

        // Fairness: both requesting, 2-beat frames, non-granted lane carries junk.
        do_reset();
        req_i = 2'b11;
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        prev_gnt = '0;
        last_term = -1;
        bidx[0] = 0;
        bidx[1] = 0;
        for (cyc_i = 0; cyc_i < 120 && g_seq.size() < 4; cyc_i++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (gnt_o[k]) begin
                    if (bidx[k] == 0) lane(k, 1'b1, 1'b1, 1'b0, 1'b0, 16'h5100 + 16'(k), 2'd0);
                    else              lane(k, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5200 + 16'(k), 2'd2);
                    bidx[k]++;
                end else begin
                    bidx[k] = 0;
                    junk(k);
                end
            end
            tick();
            if (gnt_o != '0 && prev_gnt == '0) g_seq.push_back(gnt_o);
            prev_gnt = gnt_o;
            if (tx_start_o && last_term >= 0) chk("fair_gap", cyc_i - last_term, IFG_CYC + 3);
            if (tx_term_o) last_term = cyc_i;
        end
        chk("fair_count", g_seq.size(), 4);
        for (int i = 0; i < 4 && i < g_seq.size(); i++) chk("fair_order", g_seq[i], exp_seq[i]);

        // Timeout: requester 0 granted but only sends start-less beats.
        do_reset();
        req_i = 2'b11;
        nhi = 0;
        for (int i = 0; i < 40; i++) begin
            lane(0, 1'b1, 1'b0, 1'b0, 1'b0, DATA_W'($urandom), 2'd0);
            tick();
            if (gnt_o == 2'b01) nhi++;
            else if (nhi > 0) break;
        end
        chk("to_cycles", nhi, START_TIMEOUT);
        chk("to_pulse", timeout_o, 1);
        chk("to_drop", gnt_o, 0);
        idle_lanes();
        tick();
        chk("to_once", timeout_o, 0);
        chk("to_next", gnt_o, 2'b10);
        req_i = '0;
        tick();

        // Cancel with term on beat 3.
        do_reset();
        req_i = 2'b01;
        tick();
        req_i = '0;
        lane(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hC001, 2'd0);
        tick();
        lane(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hC002, 2'd0);
        tick();
        lane(0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC003, 2'd2);
        tick();
        chk("cxl_pulse", tx_cancel_o, 1);
        chk("cxl_valid", tx_valid_o, 0);
        chk("cxl_term", tx_term_o, 0);
        chk("cxl_gnt", gnt_o, 0);
        idle_lanes();
        tick();
        chk("cxl_once", tx_cancel_o, 0);
        req_i = 2'b11;
        wait_gnt(20);
        chk("cxl_ptr", gnt_o, 2'b10);

        // Mid-frame reset.
        do_reset();
        req_i = 2'b01;
        tick();
        req_i = '0;
        lane(0, 1'b1, 1'b1, 1'b1, 1'b0, 16'hD000, 2'd2);
        tick();
        idle_lanes();
        req_i = 2'b11;
        wait_gnt(20);
        chk("mrst_pre", gnt_o, 2'b10);
        lane(1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hD101, 2'd0);
        tick();
        lane(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hD102, 2'd0);
        nreset = 1'b0;
        tick();
        chk("mrst_gnt", gnt_o, 0);
        chk("mrst_valid", tx_valid_o, 0);
        chk("mrst_cancel", tx_cancel_o, 0);
        chk("mrst_data", tx_data_o, 0);
        nreset = 1'b1;
        idle_lanes();
        tick();
        chk("mrst_first", gnt_o, 2'b01);

        // Randomized traffic in three flavours: busy, start-starved (timeouts), clean.
        pv = '{80, 50, 90};
        ps = '{25, 3, 10};
        pt = '{25, 20, 15};
        pc = '{3, 1, 0};
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 1500; c++) begin
                for (int k = 0; k < N_REQ; k++) begin
                    if ($urandom_range(0, 15) == 0) req_i[k] = ~req_i[k];
                    lane(k, 1'($urandom_range(0, 99) < pv[ph]), 1'($urandom_range(0, 99) < ps[ph]),
                         1'($urandom_range(0, 99) < pt[ph]), 1'($urandom_range(0, 99) < pc[ph]),
                         DATA_W'($urandom), LEN_W'($urandom));
                end
                nreset = ($urandom_range(0, 299) != 0);
                tick();
            end
        end
        nreset = 1'b1;
        idle_lanes();
        req_i = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
